// File: rtl/pong_engine.sv
// Game-state core for VGA Pong: ball and paddle motion, collisions, scoring
// and the match FSM. Everything advances once per video frame and leaves the
// module as registered object coordinates and scores for the renderer.
module pong_engine #(
    parameter int SCREEN_WIDTH    = 640,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int PADDLE_OFFSET   = 20,
    parameter int PADDLE_WIDTH    = 10,
    parameter int PADDLE_HEIGHT   = 100,
    parameter int PADDLE_SPEED    = 4,
    parameter int BALL_SIZE       = 7,
    parameter int BALL_SPEED_INIT = 3,
    parameter int BALL_SPEED_MAX  = 7,
    parameter int WIN_SCORE       = 9,
    parameter int SERVE_FRAMES    = 60
) (
    input  logic       clock_25M,
    input  logic       reset_n,
    input  logic       frame,
    input  logic       start,
    input  logic       btn_left_up,
    input  logic       btn_left_down,
    input  logic       btn_right_up,
    input  logic       btn_right_down,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] pad_left_y,
    output logic [9:0] pad_right_y,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] state,
    output logic       winner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Geometry in 11-bit signed so that "next position" may go negative.
    localparam logic signed [10:0] BALL_X0_C     = 11'((SCREEN_WIDTH - BALL_SIZE) / 2);
    localparam logic signed [10:0] BALL_Y0_C     = 11'((SCREEN_HEIGHT - BALL_SIZE) / 2);
    localparam logic signed [10:0] PAD_Y0_C      = 11'((SCREEN_HEIGHT - PADDLE_HEIGHT) / 2);
    localparam logic signed [10:0] PAD_Y_MAX_C   = 11'(SCREEN_HEIGHT - PADDLE_HEIGHT);
    localparam logic signed [10:0] BALL_X_MAX_C  = 11'(SCREEN_WIDTH - BALL_SIZE);
    localparam logic signed [10:0] BALL_Y_MAX_C  = 11'(SCREEN_HEIGHT - BALL_SIZE);
    localparam logic signed [10:0] L_OUTER_C     = 11'(PADDLE_OFFSET);
    localparam logic signed [10:0] L_FACE_C      = 11'(PADDLE_OFFSET + PADDLE_WIDTH);
    localparam logic signed [10:0] R_OUTER_C     = 11'(SCREEN_WIDTH - PADDLE_OFFSET);
    localparam logic signed [10:0] R_FACE_C      = 11'(SCREEN_WIDTH - PADDLE_OFFSET - PADDLE_WIDTH);
    localparam logic signed [10:0] R_HIT_X_C     = 11'(SCREEN_WIDTH - PADDLE_OFFSET - PADDLE_WIDTH - BALL_SIZE);
    localparam logic signed [10:0] PAD_SPEED_C   = 11'(PADDLE_SPEED);
    localparam logic signed [10:0] PAD_H_C       = 11'(PADDLE_HEIGHT);
    localparam logic signed [10:0] BALL_SZ_C     = 11'(BALL_SIZE);
    localparam logic [3:0]         SPEED_INIT_C  = 4'(BALL_SPEED_INIT);
    localparam logic [3:0]         SPEED_MAX_C   = 4'(BALL_SPEED_MAX);
    localparam logic [3:0]         WIN_C         = 4'(WIN_SCORE);
    localparam logic [7:0]         SERVE_LAST_C  = 8'(SERVE_FRAMES - 1);

    state_t     state_r;
    logic [9:0] ball_x_r, ball_y_r, pad_left_r, pad_right_r;
    logic [3:0] score_left_r, score_right_r, speed_r;
    logic [7:0] serve_cnt_r;
    logic       winner_r, dx_r, dy_r;   // dx_r: 1 = right, dy_r: 1 = down

    logic signed [10:0] bx_s, by_s, spd_s, nx_s, ny_s, pl_s, pr_s;
    logic               v_left_s, v_right_s, hit_left_s, hit_right_s;
    logic [9:0]         pad_left_nxt_s, pad_right_nxt_s;
    logic [3:0]         speed_up_s;

    // One paddle step with clamping to the playfield; both buttons cancel.
    function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up, input logic dn);
        logic signed [10:0] cur, dec, inc, res;
        cur = $signed({1'b0, y});
        dec = cur - PAD_SPEED_C;
        inc = cur + PAD_SPEED_C;
        if (up && !dn) begin
            res = (dec < 11'sd0) ? 11'sd0 : dec;
        end else if (dn && !up) begin
            res = (inc > PAD_Y_MAX_C) ? PAD_Y_MAX_C : inc;
        end else begin
            res = cur;
        end
        return res[9:0];
    endfunction

    // Candidate ball position, collision tests and candidate paddle positions.
    always_comb begin
        bx_s  = $signed({1'b0, ball_x_r});
        by_s  = $signed({1'b0, ball_y_r});
        pl_s  = $signed({1'b0, pad_left_r});
        pr_s  = $signed({1'b0, pad_right_r});
        spd_s = $signed({7'd0, speed_r});
        if (dx_r) begin
            nx_s = bx_s + spd_s;
        end else begin
            nx_s = bx_s - spd_s;
        end
        if (dy_r) begin
            ny_s = by_s + spd_s;
        end else begin
            ny_s = by_s - spd_s;
        end
        // Vertical overlap uses the paddles as they were before this frame.
        v_left_s    = (by_s + BALL_SZ_C > pl_s) && (by_s < pl_s + PAD_H_C);
        v_right_s   = (by_s + BALL_SZ_C > pr_s) && (by_s < pr_s + PAD_H_C);
        hit_left_s  = !dx_r && (nx_s <= L_FACE_C) && (nx_s + BALL_SZ_C > L_OUTER_C) && v_left_s;
        hit_right_s = dx_r && (nx_s + BALL_SZ_C >= R_FACE_C) && (nx_s < R_OUTER_C) && v_right_s;
        speed_up_s  = (speed_r >= SPEED_MAX_C) ? SPEED_MAX_C : speed_r + 4'd1;
        pad_left_nxt_s  = paddle_step(pad_left_r, btn_left_up, btn_left_down);
        pad_right_nxt_s = paddle_step(pad_right_r, btn_right_up, btn_right_down);
    end

    // Match FSM together with all per-frame game state.
    always_ff @(posedge clock_25M or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            ball_x_r      <= BALL_X0_C[9:0];
            ball_y_r      <= BALL_Y0_C[9:0];
            pad_left_r    <= PAD_Y0_C[9:0];
            pad_right_r   <= PAD_Y0_C[9:0];
            score_left_r  <= 4'd0;
            score_right_r <= 4'd0;
            speed_r       <= SPEED_INIT_C;
            serve_cnt_r   <= 8'd0;
            winner_r      <= 1'b0;
            dx_r          <= 1'b1;
            dy_r          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_OVER: begin
                    // Start is a level and is honoured on any cycle here.
                    if (start) begin
                        state_r       <= ST_SERVE;
                        score_left_r  <= 4'd0;
                        score_right_r <= 4'd0;
                        ball_x_r      <= BALL_X0_C[9:0];
                        ball_y_r      <= BALL_Y0_C[9:0];
                        serve_cnt_r   <= 8'd0;
                    end
                end
                ST_SERVE: begin
                    if (frame) begin
                        pad_left_r  <= pad_left_nxt_s;
                        pad_right_r <= pad_right_nxt_s;
                        if (serve_cnt_r == SERVE_LAST_C) begin
                            state_r     <= ST_PLAY;
                            serve_cnt_r <= 8'd0;
                        end else begin
                            serve_cnt_r <= serve_cnt_r + 8'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (frame) begin
                        pad_left_r  <= pad_left_nxt_s;
                        pad_right_r <= pad_right_nxt_s;
                        if (ny_s <= 11'sd0) begin
                            ball_y_r <= 10'd0;
                            dy_r     <= 1'b1;
                        end else if (ny_s >= BALL_Y_MAX_C) begin
                            ball_y_r <= BALL_Y_MAX_C[9:0];
                            dy_r     <= 1'b0;
                        end else begin
                            ball_y_r <= ny_s[9:0];
                        end
                        // A point overrides the vertical update: re-centre, keep dy.
                        if (hit_left_s) begin
                            ball_x_r <= L_FACE_C[9:0];
                            dx_r     <= 1'b1;
                            speed_r  <= speed_up_s;
                        end else if (hit_right_s) begin
                            ball_x_r <= R_HIT_X_C[9:0];
                            dx_r     <= 1'b0;
                            speed_r  <= speed_up_s;
                        end else if (nx_s < 11'sd0) begin
                            score_right_r <= score_right_r + 4'd1;
                            ball_x_r      <= BALL_X0_C[9:0];
                            ball_y_r      <= BALL_Y0_C[9:0];
                            dy_r          <= dy_r;
                            speed_r       <= SPEED_INIT_C;
                            dx_r          <= 1'b0;
                            if (score_right_r + 4'd1 == WIN_C) begin
                                state_r  <= ST_OVER;
                                winner_r <= 1'b1;
                            end else begin
                                state_r  <= ST_SERVE;
                            end
                        end else if (nx_s > BALL_X_MAX_C) begin
                            score_left_r <= score_left_r + 4'd1;
                            ball_x_r     <= BALL_X0_C[9:0];
                            ball_y_r     <= BALL_Y0_C[9:0];
                            dy_r         <= dy_r;
                            speed_r      <= SPEED_INIT_C;
                            dx_r         <= 1'b1;
                            if (score_left_r + 4'd1 == WIN_C) begin
                                state_r  <= ST_OVER;
                                winner_r <= 1'b0;
                            end else begin
                                state_r  <= ST_SERVE;
                            end
                        end else begin
                            ball_x_r <= nx_s[9:0];
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ball_x      = ball_x_r;
    assign ball_y      = ball_y_r;
    assign pad_left_y  = pad_left_r;
    assign pad_right_y = pad_right_r;
    assign score_left  = score_left_r;
    assign score_right = score_right_r;
    assign state       = state_r;
    assign winner      = winner_r;

endmodule

// File: tb/tb_pong_engine.sv
// Scoreboard bench for pong_engine: a behavioural game model predicts every
// output after each cycle; predictions are queued at drive time and popped
// and compared on the following falling edge.
module tb_pong_engine;

    logic       clock_25M;
    logic       reset_n, frame, start;
    logic       btn_left_up, btn_left_down, btn_right_up, btn_right_down;
    logic [9:0] ball_x, ball_y, pad_left_y, pad_right_y;
    logic [3:0] score_left, score_right;
    logic [1:0] state;
    logic       winner;

    pong_engine dut (
        .clock_25M      (clock_25M),
        .reset_n        (reset_n),
        .frame          (frame),
        .start          (start),
        .btn_left_up    (btn_left_up),
        .btn_left_down  (btn_left_down),
        .btn_right_up   (btn_right_up),
        .btn_right_down (btn_right_down),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .pad_left_y     (pad_left_y),
        .pad_right_y    (pad_right_y),
        .score_left     (score_left),
        .score_right    (score_right),
        .state          (state),
        .winner         (winner)
    );

    initial clock_25M = 1'b0;
    always #5 clock_25M = ~clock_25M;

    typedef struct {
        int bx; int by; int pl; int pr; int sl; int sr; int st; int win;
    } snap_t;

    snap_t sb_q[$];
    int checks = 0;
    int errors = 0;

    // model state
    int m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st, m_win;
    int m_dxr, m_dyd, m_spd, m_cnt;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic snap_t observe();
        snap_t o;
        o.bx = int'(ball_x);      o.by = int'(ball_y);
        o.pl = int'(pad_left_y);  o.pr = int'(pad_right_y);
        o.sl = int'(score_left);  o.sr = int'(score_right);
        o.st = int'(state);       o.win = int'(winner);
        return o;
    endfunction

    function automatic snap_t model_snap();
        snap_t e;
        e.bx = m_bx; e.by = m_by; e.pl = m_pl; e.pr = m_pr;
        e.sl = m_sl; e.sr = m_sr; e.st = m_st; e.win = m_win;
        return e;
    endfunction

    task automatic cmp_snap(input string pfx, input snap_t o, input snap_t e);
        check_val({pfx, "_ball_x"}, o.bx, e.bx);
        check_val({pfx, "_ball_y"}, o.by, e.by);
        check_val({pfx, "_pad_l"}, o.pl, e.pl);
        check_val({pfx, "_pad_r"}, o.pr, e.pr);
        check_val({pfx, "_score_l"}, o.sl, e.sl);
        check_val({pfx, "_score_r"}, o.sr, e.sr);
        check_val({pfx, "_state"}, o.st, e.st);
        check_val({pfx, "_winner"}, o.win, e.win);
    endtask

    function automatic void model_reset();
        m_bx = 316; m_by = 236; m_pl = 190; m_pr = 190;
        m_sl = 0; m_sr = 0; m_st = 0; m_win = 0;
        m_dxr = 1; m_dyd = 0; m_spd = 3; m_cnt = 0;
    endfunction

    function automatic int pad_move(int y, bit up, bit dn);
        if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 380) ? 380 : y + 4;
        return y;
    endfunction

    function automatic void model_step(bit f, bit s);
        int pl0, pr0, nx, ny;
        bit lh, rh;
        if (m_st == 0 || m_st == 3) begin
            if (s) begin
                m_st = 1; m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; m_cnt = 0;
            end
            return;
        end
        if (!f) return;
        pl0 = m_pl; pr0 = m_pr;
        m_pl = pad_move(m_pl, btn_left_up, btn_left_down);
        m_pr = pad_move(m_pr, btn_right_up, btn_right_down);
        if (m_st == 1) begin
            m_cnt++;
            if (m_cnt == 60) begin m_st = 2; m_cnt = 0; end
            return;
        end
        nx = m_dxr ? m_bx + m_spd : m_bx - m_spd;
        ny = m_dyd ? m_by + m_spd : m_by - m_spd;
        lh = !m_dxr && nx <= 30 && nx + 7 > 20 && m_by + 7 > pl0 && m_by < pl0 + 100;
        rh = m_dxr && nx + 7 >= 610 && nx < 620 && m_by + 7 > pr0 && m_by < pr0 + 100;
        if (!lh && !rh && (nx < 0 || nx > 633)) begin
            if (nx < 0) begin
                m_sr++; m_dxr = 0;
                if (m_sr == 9) begin m_st = 3; m_win = 1; end else m_st = 1;
            end else begin
                m_sl++; m_dxr = 1;
                if (m_sl == 9) begin m_st = 3; m_win = 0; end else m_st = 1;
            end
            m_bx = 316; m_by = 236; m_spd = 3;
            return;
        end
        if (ny <= 0) begin m_by = 0; m_dyd = 1; end
        else if (ny >= 473) begin m_by = 473; m_dyd = 0; end
        else m_by = ny;
        if (lh) begin m_bx = 30; m_dxr = 1; m_spd = (m_spd + 1 > 7) ? 7 : m_spd + 1; end
        else if (rh) begin m_bx = 603; m_dxr = 0; m_spd = (m_spd + 1 > 7) ? 7 : m_spd + 1; end
        else m_bx = nx;
    endfunction

    // drive one cycle from a falling edge, predict, then compare at next falling edge
    task automatic step(input bit f, input bit s);
        snap_t e;
        frame = f;
        start = s;
        model_step(f, s);
        sb_q.push_back(model_snap());
        @(negedge clock_25M);
        frame = 1'b0;
        start = 1'b0;
        e = sb_q.pop_front();
        cmp_snap("sb", observe(), e);
    endtask

    task automatic do_frame();
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
    endtask

    task automatic track_both();
        btn_left_up    = (m_by + 3 < m_pl + 48);
        btn_left_down  = (m_by + 3 > m_pl + 52);
        btn_right_up   = (m_by + 3 < m_pr + 48);
        btn_right_down = (m_by + 3 > m_pr + 52);
    endtask

    task automatic evade_right();
        int target;
        target = (m_by + 3 < 240) ? 380 : 0;
        btn_left_up    = 1'b0;
        btn_left_down  = 1'b0;
        btn_right_up   = (m_pr > target);
        btn_right_down = (m_pr < target);
    endtask

    task automatic clear_buttons();
        btn_left_up = 1'b0; btn_left_down = 1'b0;
        btn_right_up = 1'b0; btn_right_down = 1'b0;
    endtask

    initial begin
        snap_t o, frz;
        int k, n;
        reset_n = 1'b0; frame = 1'b0; start = 1'b0;
        clear_buttons();
        model_reset();
        repeat (2) @(negedge clock_25M);
        cmp_snap("reset", observe(), model_snap());
        reset_n = 1'b1;

        // idle frames: nothing moves
        repeat (3) do_frame();
        o = observe();
        check_val("idle_ball_x", o.bx, 316);
        check_val("idle_ball_y", o.by, 236);
        check_val("idle_pad_l", o.pl, 190);
        check_val("idle_pad_r", o.pr, 190);
        check_val("idle_state", o.st, 0);

        // start, left paddle driven to the top edge during serve
        step(1'b0, 1'b1);
        check_val("start_state", int'(state), 1);
        btn_left_up = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            do_frame();
            if (i == 47) check_val("pad_l_f47", int'(pad_left_y), 2);
            if (i == 48) check_val("pad_l_f48", int'(pad_left_y), 0);
            if (i == 50) check_val("pad_l_f50", int'(pad_left_y), 0);
        end
        check_val("pad_r_hold", int'(pad_right_y), 190);
        btn_left_up = 1'b0;
        for (int i = 51; i <= 60; i++) do_frame();
        check_val("play_after_60", int'(state), 2);
        do_frame();
        check_val("first_move_x", int'(ball_x), 319);
        check_val("first_move_y", int'(ball_y), 233);

        // rallies with both paddles chasing the ball (hits, speed-up, points)
        for (int i = 0; i < 700; i++) begin
            track_both();
            do_frame();
        end

        // asynchronous reset between clock edges
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        cmp_snap("async_rst", observe(), model_snap());
        @(negedge clock_25M);
        reset_n = 1'b1;
        clear_buttons();

        // right player dodges the ball: left wins every point
        step(1'b0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            evade_right();
            do_frame();
        end
        check_val("play_again", int'(state), 2);
        k = 0;
        while (score_left == 4'd0 && k < 200) begin
            evade_right();
            do_frame();
            k++;
            if (k == 78) check_val("top_y2", int'(ball_y), 2);
            if (k == 79) check_val("top_bounce", int'(ball_y), 0);
            if (k == 80) check_val("after_bounce", int'(ball_y), 3);
        end
        o = observe();
        check_val("pt1_score_l", o.sl, 1);
        check_val("pt1_ball_x", o.bx, 316);
        check_val("pt1_ball_y", o.by, 236);
        check_val("pt1_state", o.st, 1);

        n = 0;
        while (state != 2'd3 && n < 3000) begin
            evade_right();
            do_frame();
            n++;
        end
        o = observe();
        check_val("over_state", o.st, 3);
        check_val("over_score_l", o.sl, 9);
        check_val("over_score_r", o.sr, 0);
        check_val("over_winner", o.win, 0);

        // frozen in OVER even with buttons and frames
        frz = model_snap();
        btn_left_up = 1'b1; btn_right_down = 1'b1;
        repeat (10) do_frame();
        cmp_snap("frozen", observe(), frz);

        // restart from OVER
        clear_buttons();
        step(1'b0, 1'b1);
        o = observe();
        check_val("restart_score_l", o.sl, 0);
        check_val("restart_score_r", o.sr, 0);
        check_val("restart_state", o.st, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
